// File: rtl/parity_check_arbiter_pkg.sv
// Shared types and constants for the two-requester odd-parity checking arbiter.
// The state encoding, requester indices and default widths live here so that RTL and tooling agree.
package parity_check_arbiter_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_CNT_W  = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_CHECK  = 2'd1;
    localparam state_t ST_RESULT = 2'd2;

    localparam logic SRC_0 = 1'b0;
    localparam logic SRC_1 = 1'b1;

    // One-hot grant {req1, req0}. On a tie the requester that did not win last time is picked.
    function automatic logic [1:0] rr_pick(input logic v0, input logic v1, input logic last);
        logic [1:0] g;
        g = 2'b00;
        if (v0 && v1) begin
            g = (last == SRC_0) ? 2'b10 : 2'b01;
        end else if (v1) begin
            g = 2'b10;
        end else if (v0) begin
            g = 2'b01;
        end
        return g;
    endfunction

endpackage

// File: rtl/parity_check_arbiter_odd_parity_checker.sv
// Combinational odd-parity checker: error is high when data plus parity holds an even number of ones.
module odd_parity_checker
    import parity_check_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity,
    output logic              error
);

    assign error = ~(^{data_in, parity});

endmodule

// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sharing one odd-parity checker between two requesters, with a tagged
// result port and saturating per-requester error counters.
module parity_check_arbiter
    import parity_check_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_parity,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_parity,
    output logic              req1_ready,

    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_src,
    output logic [DATA_W-1:0] res_data,
    output logic              res_error,

    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  err_cnt0,
    output logic [CNT_W-1:0]  err_cnt1,

    output state_t            dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Handshakes: a word moves when valid && ready are both high in the same cycle. Requester
    // ready is only ever raised in IDLE, for one requester, and the requester must hold its word
    // until then. The result port holds valid and payload stable until res_ready is seen.

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              res_src_q, res_src_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_par_q, res_par_d;
    logic              res_error_q, res_error_d;
    logic [CNT_W-1:0]  err_cnt0_q, err_cnt0_d;
    logic [CNT_W-1:0]  err_cnt1_q, err_cnt1_d;

    logic [1:0]        grant;
    logic              chk_error;
    logic              res_hs;

    odd_parity_checker #(
        .DATA_W (DATA_W)
    ) u_checker (
        .data_in (res_data_q),
        .parity  (res_par_q),
        .error   (chk_error)
    );

    // Ready is qualified by rst_n so nothing is accepted while reset is held.
    always_comb begin
        grant = 2'b00;
        if (rst_n && (state_q == ST_IDLE)) begin
            grant = rr_pick(req0_valid, req1_valid, last_grant_q);
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign res_hs     = (state_q == ST_RESULT) && res_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        res_src_d    = res_src_q;
        res_data_d   = res_data_q;
        res_par_d    = res_par_q;
        res_error_d  = res_error_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    res_src_d    = grant[1] ? SRC_1 : SRC_0;
                    res_data_d   = grant[1] ? req1_data : req0_data;
                    res_par_d    = grant[1] ? req1_parity : req0_parity;
                    last_grant_d = grant[1] ? SRC_1 : SRC_0;
                    state_d      = ST_CHECK;
                end
            end
            ST_CHECK: begin
                res_error_d = chk_error;
                state_d     = ST_RESULT;
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clear takes priority over a coincident increment.
    always_comb begin
        err_cnt0_d = err_cnt0_q;
        err_cnt1_d = err_cnt1_q;
        if (clr_cnt) begin
            err_cnt0_d = '0;
            err_cnt1_d = '0;
        end else if (res_hs && res_error_q) begin
            if ((res_src_q == SRC_0) && (err_cnt0_q != CNT_MAX)) begin
                err_cnt0_d = err_cnt0_q + 1'b1;
            end
            if ((res_src_q == SRC_1) && (err_cnt1_q != CNT_MAX)) begin
                err_cnt1_d = err_cnt1_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= SRC_1;
            res_src_q    <= SRC_0;
            res_data_q   <= '0;
            res_par_q    <= 1'b0;
            res_error_q  <= 1'b0;
            err_cnt0_q   <= '0;
            err_cnt1_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            res_src_q    <= res_src_d;
            res_data_q   <= res_data_d;
            res_par_q    <= res_par_d;
            res_error_q  <= res_error_d;
            err_cnt0_q   <= err_cnt0_d;
            err_cnt1_q   <= err_cnt1_d;
        end
    end

    assign res_valid = (state_q == ST_RESULT);
    assign res_src   = res_src_q;
    assign res_data  = res_data_q;
    assign res_error = res_error_q;
    assign err_cnt0  = err_cnt0_q;
    assign err_cnt1  = err_cnt1_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Bench for parity_check_arbiter: directed scenarios plus random traffic, checked by a
// cycle-level reference model and an expected-result queue.
module tb_parity_check_arbiter;

  localparam int DATA_W  = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              req0_valid, req0_parity, req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid, req1_parity, req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic              res_valid, res_ready, res_src, res_error;
  logic [DATA_W-1:0] res_data;
  logic              clr_cnt;
  logic [CNT_W-1:0]  err_cnt0, err_cnt1;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;
  int rr_mode = 0;

  // model state: 0 idle, 1 checking, 2 result presented
  int   m_state = 0;
  bit   m_last  = 1'b1;
  int   m_cnt0  = 0;
  int   m_cnt1  = 0;
  logic [DATA_W+1:0] exp_q[$];

  parity_check_arbiter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_parity (req0_parity),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_parity (req1_parity),
    .req1_ready  (req1_ready),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_src     (res_src),
    .res_data    (res_data),
    .res_error   (res_error),
    .clr_cnt     (clr_cnt),
    .err_cnt0    (err_cnt0),
    .err_cnt1    (err_cnt1),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic send(input int src, input logic [DATA_W-1:0] d, input logic p);
    bit got;
    int n;
    if (src == 0) begin
      req0_valid = 1'b1; req0_data = d; req0_parity = p;
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_parity = p;
    end
    got = 1'b0;
    n = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      got = (src == 0) ? req0_ready : req1_ready;
      n++;
    end
    chk($sformatf("accept_timeout_req%0d", src), int'(got), 1);
    @(posedge clk);
    #1;
    if (src == 0) req0_valid = 1'b0;
    else          req1_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0: res_ready = 1'b1;
        1: res_ready = 1'($urandom_range(0, 1));
        2: res_ready = 1'b0;
        default: ;
      endcase
    end
  end

  // scoreboard / monitor, sampling on the falling edge
  always @(negedge clk) begin
    int g;
    logic [1:0] er;
    logic [DATA_W-1:0] d;
    logic p;
    logic [DATA_W+1:0] item;
    if (!rst_n) begin
      chk("rst_ready", int'({req1_ready, req0_ready}), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_res_src", int'(res_src), 0);
      chk("rst_res_data", int'(res_data), 0);
      chk("rst_res_error", int'(res_error), 0);
      chk("rst_cnt0", int'(err_cnt0), 0);
      chk("rst_cnt1", int'(err_cnt1), 0);
      chk("rst_state", int'(dbg_state), 0);
      m_state = 0;
      m_last  = 1'b1;
      m_cnt0  = 0;
      m_cnt1  = 0;
      exp_q.delete();
    end else begin
      g  = 0;
      er = 2'b00;
      if (m_state == 0 && (req0_valid || req1_valid)) begin
        if (req0_valid && req1_valid) g = m_last ? 0 : 1;
        else g = req1_valid ? 1 : 0;
        er = (g == 1) ? 2'b10 : 2'b01;
      end
      chk("ready", int'({req1_ready, req0_ready}), int'(er));
      chk("res_valid", int'(res_valid), int'(m_state == 2));
      chk("state", int'(dbg_state), m_state);
      chk("err_cnt0", int'(err_cnt0), m_cnt0);
      chk("err_cnt1", int'(err_cnt1), m_cnt1);
      if (m_state == 2 && res_valid) begin
        item = exp_q[0];
        chk("res_src", int'(res_src), int'(item[DATA_W+1]));
        chk("res_data", int'(res_data), int'(item[DATA_W:1]));
        chk("res_error", int'(res_error), int'(item[0]));
      end
      if (clr_cnt) begin
        m_cnt0 = 0;
        m_cnt1 = 0;
      end else if (m_state == 2 && res_ready && exp_q[0][0]) begin
        if (exp_q[0][DATA_W+1]) m_cnt1 = (m_cnt1 < CNT_MAX) ? m_cnt1 + 1 : CNT_MAX;
        else                    m_cnt0 = (m_cnt0 < CNT_MAX) ? m_cnt0 + 1 : CNT_MAX;
      end
      if (m_state == 2) begin
        if (res_ready) begin
          void'(exp_q.pop_front());
          m_state = 0;
        end
      end else if (m_state == 1) begin
        m_state = 2;
      end else if (er != 2'b00) begin
        d = (g == 1) ? req1_data : req0_data;
        p = (g == 1) ? req1_parity : req0_parity;
        exp_q.push_back({1'(g), d, 1'(($countones({d, p}) % 2) == 0)});
        m_last  = 1'(g);
        m_state = 1;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_parity = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_parity = 1'b0;
    res_ready = 1'b0;
    clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // clean word from req0, then an error word from req1
    send(0, 4'b0000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    send(1, 4'b0011, 1'b0);
    repeat (4) @(negedge clk);
    chk("cnt1_after_error", int'(err_cnt1), 1);
    @(posedge clk);
    #1;

    // backpressure with the other requester waiting
    rr_mode = 2;
    fork
      send(1, 4'b0101, 1'b0);
      begin
        repeat (14) @(posedge clk);
        #1;
        rr_mode = 0;
      end
      begin
        @(posedge clk);
        #1;
        send(0, 4'b1110, 1'b1);
      end
    join
    repeat (4) @(posedge clk);

    // both requesters streaming: grants alternate starting with req0 after reset
    do_reset(2);
    fork
      for (int i = 0; i < 4; i++) send(0, 4'(i), 1'(i));
      for (int i = 0; i < 4; i++) send(1, 4'(i + 8), 1'b1);
    join
    repeat (4) @(posedge clk);
    #1;

    // saturation then clear coinciding with an error handshake
    for (int i = 0; i < 8; i++) send(0, 4'b0011, 1'b0);
    repeat (4) @(negedge clk);
    chk("cnt0_saturated", int'(err_cnt0), CNT_MAX);
    @(posedge clk);
    #1;
    rr_mode = 2;
    send(0, 4'b1111, 1'b0);
    rr_mode = 3;
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    res_ready = 1'b0;
    rr_mode = 0;
    @(negedge clk);
    chk("cnt0_clear_wins", int'(err_cnt0), 0);

    // reset while the accepted word is being checked; it must never appear
    @(posedge clk);
    #1;
    send(1, 4'b0110, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_valid", int'(res_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // random traffic with random backpressure and occasional clears
    rr_mode = 1;
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        send(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        send(1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 200; i++) begin
        @(posedge clk);
        #1;
        clr_cnt = ($urandom_range(0, 19) == 0);
      end
    join
    clr_cnt = 1'b0;
    rr_mode = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_check_arbiter.md
# parity_check_arbiter

Shares one odd-parity checker between two requesters that each deliver a DATA_W-bit word plus parity bit over a valid/ready handshake. A round-robin FSM grants one requester at a time, registers the word, evaluates odd parity and presents a tagged result on a valid/ready output port. It also keeps saturating per-requester error counters for status readout.

## Interface
- DATA_W, 4: data word width (bits), ≥1
- CNT_W, 8: per-requester error counter width, ≥1

- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous and active-low
- req0_valid  input  1  requester 0 has a word
- req0_data  input  DATA_W  requester 0 word
- req0_parity  input  1  requester 0 parity bit
- req0_ready  output  1  requester 0 word accepted this cycle
- req1_valid / req1_data / req1_parity / req1_ready: same as requester 0, for requester 1
- res_valid  output  1  result available
- res_ready  input  1  consumer takes result
- res_src  output  1  requester that produced the result (0/1)
- res_data  output  DATA_W  checked word
- res_error  output  1  1 = odd-parity violation
- clr_cnt  input  1  synchronous clear of both counters
- err_cnt0, err_cnt1  output  CNT_W  saturating error counts

## Operation
- Odd parity: res_error = ~(^{data, parity}). An even count of ones across data+parity is an error.
- FSM states: IDLE, CHECK, RESULT.
  - IDLE: if any reqN_valid, grant one requester and assert its reqN_ready combinationally in that cycle only. Capture data/parity/src, then go to CHECK. With no valid, stay.
  - CHECK: register the parity result into res_error. Go to RESULT.
  - RESULT: res_valid=1; res_src/res_data/res_error are held stable. When res_ready=1, go to IDLE and update the counter.
- Arbitration: round-robin on last_grant.
  - Single valid: grant it.
  - Both valid: grant ~last_grant.
  - last_grant updates on each grant.
- Ready is never asserted outside IDLE. At most one reqN_ready is high per cycle.
- Counters:
  - On the RESULT handshake with res_error=1, err_cnt[res_src] increments, saturating at 2^CNT_W-1.
  - clr_cnt=1 zeroes both counters. If clr_cnt coincides with an increment, clear wins.
- Requesters must hold valid/data/parity stable until ready. An unaccepted word may be withdrawn without effect.

## Timing
- Reset values: state=IDLE, last_grant=1 (so requester 0 wins the first tie), res_valid=0, res_src=0, res_data=0, res_error=0, err_cnt0=err_cnt1=0, req0_ready=req1_ready=0.
- Latency: accept in cycle N, res_valid high in cycle N+2.
- Throughput: with res_ready tied high, one word per 3 cycles. Handshake at N+2, IDLE at N+3, next accept at N+3.
- Counter value is visible the cycle after the result handshake.
- Backpressure: while res_ready=0, the block stays in RESULT indefinitely and both requesters see ready=0.
- Reset mid-operation (any state) returns everything to reset values immediately. The in-flight word is dropped and not counted.

## Structure
- Shared package holds:
  - State encoding typedef: IDLE=2'd0, CHECK=2'd1, RESULT=2'd2.
  - Requester index constants: SRC_0, SRC_1.
  - Default widths: DATA_W, CNT_W.
- One sub-module: the existing combinational odd_parity_checker (data_in, parity → error), instantiated once on the captured registers. DATA_W=4 matches its width. Other widths use the reduction-XOR equation above.
- Arbiter, FSM and counters stay flat in the top module.

## Test plan
- Reset, then req0 sends data=4'b0000, parity=1 → req0_ready pulses one cycle; res_valid two cycles later with res_src=0, res_data=0, res_error=0; err_cnt0 stays 0.
- req1 sends data=4'b0011, parity=0 → res_error=1, res_src=1; err_cnt1=1 the cycle after the handshake.
- Both valid continuously, res_ready=1 → grants alternate 0,1,0,1 starting with 0. No cycle has both readys high.
- res_ready held 0 for 10 cycles in RESULT → res_data, res_src and res_error stay stable; no reqN_ready; single counter update on release.
- CNT_W=2: eight error words from req0 → err_cnt0 saturates at 3. Assert clr_cnt together with a ninth error handshake → err_cnt0=0.
- Assert rst_n=0 during CHECK → res_valid=0, counters=0, state IDLE. The dropped word is never reported.
